cla_pipe_addsub: RTL and testbench

- Parametrised, pipelined carry-lookahead adder/subtractor. Successor to the team's 8-bit single-cycle CLA.
- The WIDTH-bit operation is split into BLOCK-bit CLA slices. Each slice is one pipeline stage, and its carry is registered into the next stage.
- Adds a subtract mode, signed-overflow and zero flags, and a valid/ready elastic handshake on both sides.
- Sits in the datapath between operand sources and downstream accumulators/ALU result muxes.

---
 rtl/cla_pkg.sv | 16 +
 rtl/cla_block.sv | 49 ++++
 rtl/cla_pipe_addsub.sv | 137 +++++++++++++
 tb/tb_cla_pipe_addsub.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared constants and configuration checks for the pipelined CLA adder/subtractor.
package cla_pkg;

    localparam int WIDTH_DEFAULT = 16;
    localparam int BLOCK_DEFAULT = 4;

    // Mode encoding on in_sub
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Legal geometry: slice width 2..8 and the word splits into whole slices
    function automatic bit cfg_ok(input int width, input int block);
        return (block >= 2) && (block <= 8) && (width >= block) && ((width % block) == 0);
    endfunction

endpackage

// File: rtl/cla_block.sv
// Combinational BLOCK-bit carry-lookahead slice. Every internal carry is a flat
// OR of generate terms qualified by propagate chains, so no carry ripples.
module cla_block #(
    parameter int BLOCK = 4
) (
    input  logic [BLOCK-1:0] a,
    input  logic [BLOCK-1:0] b,
    input  logic             cin,
    output logic [BLOCK-1:0] sum,
    output logic             cout,
    output logic             c_msb_in
);

    logic [BLOCK-1:0] g;
    logic [BLOCK-1:0] p;
    logic [BLOCK:0]   c;

    assign g = a & b;
    assign p = a | b;

    // Expand each carry c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin
    always_comb begin : lookahead
        logic prop;
        // NOTE: blocking assignments in combinational logic, because prop and c
        // are accumulated step by step within a single evaluation.
        prop = 1'b1;
        c    = '0;
        c[0] = cin;
        for (int i = 0; i < BLOCK; i++) begin
            for (int j = 0; j <= i; j++) begin
                prop = 1'b1;
                for (int k = j + 1; k <= i; k++) begin
                    prop = prop & p[k];
                end
                c[i+1] = c[i+1] | (g[j] & prop);
            end
            prop = 1'b1;
            for (int k = 0; k <= i; k++) begin
                prop = prop & p[k];
            end
            c[i+1] = c[i+1] | (cin & prop);
        end
    end

    assign sum      = a ^ b ^ c[BLOCK-1:0];
    assign cout     = c[BLOCK];
    assign c_msb_in = c[BLOCK-1];

endmodule

// File: rtl/cla_pipe_addsub.sv
// Pipelined carry-lookahead adder/subtractor. Each stage resolves one BLOCK-bit
// slice and registers its carry into the next; stages are elastic so bubbles
// collapse and the output can be stalled without loss.
module cla_pipe_addsub
    import cla_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT,
    parameter int BLOCK = BLOCK_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int STAGES = WIDTH / BLOCK;

    if (!cfg_ok(WIDTH, BLOCK)) begin : g_cfg_check
        $error("cla_pipe_addsub: WIDTH must be a multiple of BLOCK, with BLOCK in 2..8");
    end

    logic [STAGES-1:0] v_q;
    logic [STAGES-1:0] c_q;
    logic [STAGES-1:0] ld;
    logic [WIDTH-1:0]  a_q [STAGES];
    logic [WIDTH-1:0]  b_q [STAGES];
    logic [WIDTH-1:0]  s_q [STAGES];
    logic              slice_cmsb [STAGES];
    logic              ovf_q;
    logic              zero_q;
    logic [WIDTH-1:0]  b_eff;
    logic              c_eff;

    // Subtract is A + ~B + 1; carry-in is only honoured in add mode
    assign b_eff = (in_sub == MODE_ADD) ? in_b : ~in_b;
    assign c_eff = (in_sub == MODE_SUB) ? 1'b1 : in_cin;

    // A stage can load unless it and every stage after it are full and the output is stalled
    for (genvar k = 0; k < STAGES; k++) begin : g_ld
        assign ld[k] = out_ready | ~(&v_q[STAGES-1:k]);
    end

    assign in_ready = ld[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [WIDTH-1:0] a_src;
        logic [WIDTH-1:0] b_src;
        logic [WIDTH-1:0] s_src;
        logic [WIDTH-1:0] s_d;
        logic             c_src;
        logic             v_src;
        logic [BLOCK-1:0] sl_sum;
        logic             sl_cout;

        if (k == 0) begin : g_src
            assign a_src = in_a;
            assign b_src = b_eff;
            assign s_src = '0;
            assign c_src = c_eff;
            assign v_src = in_valid;
        end else begin : g_src
            assign a_src = a_q[k-1];
            assign b_src = b_q[k-1];
            assign s_src = s_q[k-1];
            assign c_src = c_q[k-1];
            assign v_src = v_q[k-1];
        end

        cla_block #(.BLOCK(BLOCK)) u_slice (
            .a        (a_src[k*BLOCK +: BLOCK]),
            .b        (b_src[k*BLOCK +: BLOCK]),
            .cin      (c_src),
            .sum      (sl_sum),
            .cout     (sl_cout),
            .c_msb_in (slice_cmsb[k])
        );

        // Splice this slice's sum bits into the partial result
        always_comb begin
            // NOTE: s_d gets a full default before the partial overwrite, so no
            // bit is left unassigned on any path and no latch is inferred.
            s_d = s_src;
            s_d[k*BLOCK +: BLOCK] = sl_sum;
        end

        // Stage register: advance on load; data only moves when a transaction arrives
        always_ff @(posedge clk or negedge rst_n) begin
            // NOTE: data registers are reset too (not just valid), so out_sum and
            // the flags read 0 out of reset; sequential state uses <= only.
            if (!rst_n) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end else if (ld[k]) begin
                v_q[k] <= v_src;
                if (v_src) begin
                    a_q[k] <= a_src;
                    b_q[k] <= b_src;
                    s_q[k] <= s_d;
                    c_q[k] <= sl_cout;
                end
            end
        end

        if (k == STAGES - 1) begin : g_flags
            // Flags are formed as the final slice completes the word
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    ovf_q  <= 1'b0;
                    zero_q <= 1'b0;
                end else if (ld[k] && v_src) begin
                    ovf_q  <= slice_cmsb[k] ^ sl_cout;
                    zero_q <= ~|s_d;
                end
            end
        end
    end

    assign out_valid = v_q[STAGES-1];
    assign out_sum   = s_q[STAGES-1];
    assign out_cout  = c_q[STAGES-1];
    assign out_ovf   = ovf_q;
    assign out_zero  = zero_q;

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Scoreboard bench for cla_pipe_addsub: drivers push expected results when a
// transaction is accepted, a monitor pops and compares whenever a result leaves.
module tb_cla_pipe_addsub;

    localparam int W  = 16;
    localparam int B  = 4;
    localparam int ST = W / B;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        logic         zero;
        int           acc;
        bit           chk_lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
    logic         in_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;
    logic         out_zero;

    int        total = 0;
    int        bad   = 0;
    int        cyc   = 0;
    exp_t      exp_q[$];
    exp_t      mon_e;
    bit        held_v = 1'b0;
    logic [W+2:0] held;
    bit        rnd_done = 1'b0;

    cla_pipe_addsub #(.WIDTH(W), .BLOCK(B)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] sum, input logic cout, ovf, zero);
        exp_t e;
        e.sum = sum; e.cout = cout; e.ovf = ovf; e.zero = zero;
        e.acc = 0; e.chk_lat = 1'b0;
        return e;
    endfunction

    // Reference: plain integer arithmetic on signed and unsigned views of the operands
    function automatic exp_t model(input logic [W-1:0] a, b, input logic cin, sub);
        exp_t   e;
        longint sa, sb, ua, ub, ci, r, ur, maxv, minv;
        sa = $signed(a);
        sb = $signed(b);
        ua = a;
        ub = b;
        ci = cin;
        maxv = (longint'(1) << (W - 1)) - 1;
        minv = -(longint'(1) << (W - 1));
        if (sub) begin
            r  = sa - sb;
            ur = ua - ub;
            e.cout = (ua >= ub);
        end else begin
            r  = sa + sb + ci;
            ur = ua + ub + ci;
            e.cout = (ur >= (longint'(1) << W));
        end
        e.sum  = ur[W-1:0];
        e.ovf  = (r > maxv) || (r < minv);
        e.zero = (e.sum == '0);
        e.acc = 0;
        e.chk_lat = 1'b0;
        return e;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0:       v = '0;
            1:       v = '1;
            2:       v = {1'b1, {(W-1){1'b0}}};
            3:       v = {1'b0, {(W-1){1'b1}}};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Present one transaction until accepted; record the expected result on acceptance
    task automatic issue(input logic [W-1:0] a, b, input logic cin, sub, input exp_t e, input bit chk_lat);
        bit done  = 1'b0;
        int tries = 0;
        exp_t x = e;
        while (!done && tries < 200) begin
            @(negedge clk);
            in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; in_sub = sub;
            #1;
            if (in_ready) begin
                x.acc = cyc + 1;
                x.chk_lat = chk_lat;
                exp_q.push_back(x);
                done = 1'b1;
            end
            tries++;
        end
        if (!done) check("issue_timeout", done, 1'b1);
    endtask

    task automatic issue_rand(input bit chk_lat);
        logic [W-1:0] a = rnd_op();
        logic [W-1:0] b = rnd_op();
        logic cin = 1'($urandom);
        logic sub = 1'($urandom);
        issue(a, b, cin, sub, model(a, b, cin, sub), chk_lat);
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain(input int max_cyc);
        int n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        #3;
        check("drain_empty", exp_q.size(), 0);
    endtask

    // Monitor: compare every result that leaves, and hold-stability while stalled
    always @(negedge clk) begin
        #2;
        if (!rst_n) begin
            held_v = 1'b0;
        end else if (out_valid) begin
            if (held_v) check("hold_stable", {out_cout, out_ovf, out_zero, out_sum}, held);
            if (out_ready) begin
                held_v = 1'b0;
                if (exp_q.size() == 0) begin
                    check("unexpected_output", out_valid, 1'b0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("result", {out_cout, out_ovf, out_zero, out_sum},
                          {mon_e.cout, mon_e.ovf, mon_e.zero, mon_e.sum});
                    if (mon_e.chk_lat) check("latency", cyc - mon_e.acc, ST - 1);
                end
            end else begin
                held_v = 1'b1;
                held   = {out_cout, out_ovf, out_zero, out_sum};
            end
        end else begin
            held_v = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (total=%0d bad=%0d)", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int guard;
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
        in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b0;

        // Reset state
        #12;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_sum", out_sum, '0);
        check("rst_out_zero", out_zero, 1'b0);
        check("rst_out_cout", out_cout, 1'b0);
        check("rst_out_ovf", out_ovf, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_reset", in_ready, 1'b1);

        // Directed corner cases, back-to-back, latency checked
        out_ready = 1'b1;
        issue(16'hFFFF, 16'h0000, 1'b1, 1'b0, mk(16'h0000, 1'b1, 1'b0, 1'b1), 1'b1);
        issue(16'h7FFF, 16'h0001, 1'b0, 1'b0, mk(16'h8000, 1'b0, 1'b1, 1'b0), 1'b1);
        issue(16'h0003, 16'h0001, 1'b0, 1'b1, mk(16'h0002, 1'b1, 1'b0, 1'b0), 1'b1);
        issue(16'h8000, 16'h0001, 1'b0, 1'b1, mk(16'h7FFF, 1'b1, 1'b1, 1'b0), 1'b1);
        issue(16'h0001, 16'h0002, 1'b0, 1'b1, mk(16'hFFFF, 1'b0, 1'b0, 1'b0), 1'b1);
        issue(16'h0005, 16'h0003, 1'b1, 1'b1, mk(16'h0002, 1'b1, 1'b0, 1'b0), 1'b1);
        issue(16'h1234, 16'h4321, 1'b0, 1'b0, mk(16'h5555, 1'b0, 1'b0, 1'b0), 1'b1);
        issue(16'h8000, 16'h8000, 1'b0, 1'b0, mk(16'h0000, 1'b1, 1'b1, 1'b1), 1'b1);
        issue(16'h0000, 16'h0000, 1'b0, 1'b1, mk(16'h0000, 1'b1, 1'b0, 1'b1), 1'b1);
        issue(16'h00FF, 16'h0F01, 1'b1, 1'b0, mk(16'h1001, 1'b0, 1'b0, 1'b0), 1'b1);
        idle();
        drain(50);

        // Stream of 10 with no backpressure: consecutive results at fixed latency
        for (int i = 0; i < 10; i++) issue_rand(1'b1);
        idle();
        drain(50);

        // Same stream with a 6-cycle output stall mid-stream
        fork
            begin
                for (int i = 0; i < 10; i++) issue_rand(1'b0);
                idle();
            end
            begin
                repeat (3) @(negedge clk);
                out_ready = 1'b0;
                repeat (5) @(negedge clk);
                #3;
                check("in_ready_full_stall", in_ready, 1'b0);
                @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain(100);

        // Reset with transactions in flight
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) issue_rand(1'b0);
        idle();
        @(negedge clk);
        #3;
        check("out_valid_before_reset", out_valid, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("out_valid_async_reset", out_valid, 1'b0);
        check("out_sum_async_reset", out_sum, '0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        #3;
        check("idle_after_reset", out_valid, 1'b0);

        // Randomised traffic with random backpressure
        acc = 0;
        guard = 0;
        fork
            begin
                while (acc < 10000 && guard < 60000) begin
                    logic [W-1:0] a;
                    logic [W-1:0] b;
                    logic cin;
                    logic sub;
                    @(negedge clk);
                    a = rnd_op(); b = rnd_op();
                    cin = 1'($urandom); sub = 1'($urandom);
                    in_valid = ($urandom_range(0, 9) < 7);
                    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
                    #1;
                    if (in_valid && in_ready) begin
                        exp_q.push_back(model(a, b, cin, sub));
                        acc++;
                    end
                    guard++;
                end
                @(negedge clk);
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(negedge clk);
                    out_ready = ($urandom_range(0, 9) < 7);
                end
                out_ready = 1'b1;
            end
        join
        check("rnd_accepted", acc, 10000);
        drain(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
